// File: rtl/arith_seq_unit.sv
// ---------------------------------------------------------------------------
// arith_seq_unit
//
// Multi-cycle unsigned arithmetic unit. One shared iterative multiplier
// computes in^2, in^3, in! or in^in over N cycles, using a start/busy/done
// handshake. Results are truncated to OUT_W bits. An overflow on any step is
// flagged on ovf rather than rejected.
//
// Parameters
//   IN_W   operand width (>= 2)
//   OUT_W  result / accumulator width (>= 2*IN_W)
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while busy=0
//   in     in   IN_W   operand, captured on the accepted start
//   pcode  in   2      0: in^2, 1: in^3, 2: in!, 3: in^in
//   busy   out  1      high while CALC is in progress
//   done   out  1      one-cycle pulse when out/ovf are valid
//   out    out  OUT_W  result, held until the next done
//   ovf    out  1      overflow of any step of the last operation
// ---------------------------------------------------------------------------
module arith_seq_unit #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       pcode,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    localparam int PROD_W = OUT_W + IN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SQUARE = 2'd0,
        OP_CUBE   = 2'd1,
        OP_FACT   = 2'd2,
        OP_POWER  = 2'd3
    } op_t;

    state_t            state;
    op_t               op_q;
    logic [IN_W-1:0]   in_q;
    logic [OUT_W-1:0]  acc;
    logic [IN_W-1:0]   step;
    logic              ovf_int;

    logic [IN_W-1:0]   factor;
    logic [IN_W-1:0]   n_steps;
    logic [PROD_W-1:0] prod;
    logic              prod_ovf;
    logic              last_step;

    // Factor and step count for the captured operation; the multiplier is
    // formed wide enough that nothing is lost before the overflow test.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        factor  = in_q;
        n_steps = IN_W'(2);
        unique case (op_q)
            OP_SQUARE: begin
                factor  = in_q;
                n_steps = IN_W'(2);
            end
            OP_CUBE: begin
                factor  = in_q;
                n_steps = IN_W'(3);
            end
            OP_FACT: begin
                factor  = step;
                n_steps = (in_q == '0) ? IN_W'(1) : in_q;
            end
            OP_POWER: begin
                // 0^0 is defined as 1: one step multiplying by 1.
                factor  = (in_q == '0) ? IN_W'(1) : in_q;
                n_steps = (in_q == '0) ? IN_W'(1) : in_q;
            end
            default: begin
                factor  = in_q;
                n_steps = IN_W'(2);
            end
        endcase
        prod      = PROD_W'(acc) * PROD_W'(factor);
        prod_ovf  = |prod[PROD_W-1:OUT_W];
        last_step = (step == n_steps);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_SQUARE;
            in_q    <= '0;
            acc     <= OUT_W'(1);
            step    <= '0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            ovf     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= op_t'(pcode);
                        in_q    <= in;
                        acc     <= OUT_W'(1);
                        step    <= IN_W'(1);
                        ovf_int <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end else begin
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    acc <= prod[OUT_W-1:0];
                    if (last_step) begin
                        out   <= prod[OUT_W-1:0];
                        ovf   <= ovf_int | prod_ovf;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ovf_int <= ovf_int | prod_ovf;
                        // step stops at N, which is at most 2^IN_W-1.
                        step    <= step + IN_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_arith_seq_unit
//
// Directed testbench for arith_seq_unit (IN_W=4, OUT_W=16). Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_arith_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  in;
    logic [1:0]  pcode;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        ovf;

    int errors;
    int checks;

    arith_seq_unit #(.IN_W(4), .OUT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in),
        .pcode (pcode),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; returns right after the accepting edge.
    task automatic launch(input logic [3:0] a, input logic [1:0] p);
        in    = a;
        pcode = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for done; lat counts edges from the accepting edge (which is 1).
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d edges", lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in    = '0;
        pcode = '0;
        #12;
        checks++;
        if ({busy, done, ovf, out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ovf=%b out=%0d, want all 0",
                     busy, done, ovf, out);
        end
        #3 rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done !== 1'b0 || busy !== 1'b0) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL idle_quiet: %0d cycles with busy/done, want 0", seen);
            end
        end
    endtask

    // Generic operation check: value, overflow flag and latency.
    task automatic run_check(input string name, input logic [3:0] a,
                             input logic [1:0] p, input logic [15:0] exp_out,
                             input logic exp_ovf, input bit chk_out,
                             input int exp_lat);
        int lat;
        launch(a, p);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy=%b after accept, want 1", name, busy);
        end
        wait_done(1, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, want %0d", name, lat, exp_lat);
        end
        if (chk_out) begin
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL %s_out: got %0d, want %0d", name, out, exp_out);
            end
        end
        checks++;
        if (ovf !== exp_ovf || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf: ovf=%b busy=%b, want ovf=%b busy=0",
                     name, ovf, busy, exp_ovf);
        end
        tick();
        checks++;
        if (done !== 1'b0 || (chk_out && out !== exp_out)) begin
            errors++;
            $display("FAIL %s_hold: done=%b out=%0d, want done=0 out=%0d",
                     name, done, out, exp_out);
        end
    endtask

    task automatic test_square_cube();
        run_check("sq7",   4'd7,  2'd0, 16'd49,   1'b0, 1'b1, 3);
        run_check("cube15", 4'd15, 2'd1, 16'd3375, 1'b0, 1'b1, 4);
    endtask

    task automatic test_factorial();
        run_check("fact0", 4'd0, 2'd2, 16'd1,     1'b0, 1'b1, 2);
        run_check("fact1", 4'd1, 2'd2, 16'd1,     1'b0, 1'b1, 2);
        run_check("fact8", 4'd8, 2'd2, 16'd40320, 1'b0, 1'b1, 9);
        run_check("fact9", 4'd9, 2'd2, 16'd35200, 1'b1, 1'b1, 10);
    endtask

    task automatic test_power();
        run_check("pow5",  4'd5,  2'd3, 16'd3125, 1'b0, 1'b1, 6);
        run_check("pow0",  4'd0,  2'd3, 16'd1,    1'b0, 1'b1, 2);
        run_check("pow15", 4'd15, 2'd3, 16'd0,    1'b1, 1'b0, 16);
    endtask

    // start held high and operands changed during CALC must not matter.
    task automatic test_handshake();
        int lat;
        in    = 4'd15;
        pcode = 2'd1;
        start = 1'b1;
        tick();
        in    = 4'd2;
        pcode = 2'd0;
        tick();
        in    = 4'd9;
        pcode = 2'd2;
        tick();
        start = 1'b0;
        wait_done(3, lat);
        checks++;
        if (lat != 4 || out !== 16'd3375 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL held_start: lat=%0d out=%0d ovf=%b, want lat=4 out=3375 ovf=0",
                     lat, out, ovf);
        end
        tick();
    endtask

    // start in the DONE cycle launches the next operation with no gap.
    task automatic test_back_to_back();
        int lat;
        launch(4'd3, 2'd0);
        wait_done(1, lat);
        checks++;
        if (out !== 16'd9) begin
            errors++;
            $display("FAIL b2b_first: got %0d, want 9", out);
        end
        launch(4'd4, 2'd1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || out !== 16'd9) begin
            errors++;
            $display("FAIL b2b_launch: busy=%b done=%b out=%0d, want 1 0 9",
                     busy, done, out);
        end
        wait_done(1, lat);
        checks++;
        if (lat != 4 || out !== 16'd64 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d out=%0d ovf=%b, want 4 64 0",
                     lat, out, ovf);
        end
        tick();
    endtask

    // Reset in the 4th CALC cycle of 8! aborts with no done.
    task automatic test_abort();
        int seen;
        launch(4'd8, 2'd2);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 16'd0 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: busy=%b out=%0d done=%b ovf=%b, want all 0",
                     busy, out, done, ovf);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses, want 0", seen);
        end
        run_check("after_abort", 4'd6, 2'd2, 16'd720, 1'b0, 1'b1, 7);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_square_cube();
        test_factorial();
        test_power();
        test_handshake();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
